// File: rtl/mem_bus_responder_if.sv
// Unified mem_cmd/mem_rsp bus between the CPU bus arbiter (master) and a memory target (slave).
interface mem_bus_responder_if;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_instr;
    logic        mem_cmd_wr;
    logic [31:0] mem_cmd_addr;
    logic [31:0] mem_cmd_wdata;
    logic [3:0]  mem_cmd_be;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;

    modport master (
        output mem_cmd_valid,
        output mem_cmd_instr,
        output mem_cmd_wr,
        output mem_cmd_addr,
        output mem_cmd_wdata,
        output mem_cmd_be,
        input  mem_cmd_ready,
        input  mem_rsp_ready,
        input  mem_rsp_rdata
    );

    modport slave (
        input  mem_cmd_valid,
        input  mem_cmd_instr,
        input  mem_cmd_wr,
        input  mem_cmd_addr,
        input  mem_cmd_wdata,
        input  mem_cmd_be,
        output mem_cmd_ready,
        output mem_rsp_ready,
        output mem_rsp_rdata
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Bus target decoding commands to an internal byte-enabled RAM, a 4 KB peripheral req/ack window, or unmapped space.
// Define MEM_BUS_TIMEOUT_EN to add a peripheral ack timeout with a sticky timeout_err output.
module mem_bus_responder #(
    parameter int          RAM_WORDS      = 2048,
    parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
    parameter logic [31:0] PERIPH_BASE    = 32'h8000_0000,
    parameter logic [31:0] UNMAPPED_DATA  = 32'hDEAD_BEEF,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset_,
    mem_bus_responder_if.slave        bus,
    output logic                      periph_req,
    output logic                      periph_wr,
    output logic [11:0]               periph_addr,
    output logic [31:0]               periph_wdata,
    output logic [3:0]                periph_be,
    input  logic                      periph_ack,
    input  logic [31:0]               periph_rdata
`ifdef MEM_BUS_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);

    localparam int          AW       = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_SIZE = 33'(RAM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RSP   = 2'd1,
        PWAIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   ram [RAM_WORDS];
    logic          cmd_ready;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          accept;
    logic          ram_hit;
    logic          periph_hit;
    logic          timeout_hit;
    logic          pwait_done;
    logic [32:0]   ram_offset;
    logic [AW-1:0] ram_idx;
    logic          unused_bits;

    assign bus.mem_cmd_ready = cmd_ready;
    assign bus.mem_rsp_ready = rsp_ready;
    assign bus.mem_rsp_rdata = rsp_rdata;

    // An address below RAM_BASE wraps the 33-bit offset high, so one compare covers both bounds.
    assign ram_offset = {1'b0, bus.mem_cmd_addr} - {1'b0, RAM_BASE};
    assign ram_hit    = (ram_offset < RAM_SIZE);
    assign periph_hit = (bus.mem_cmd_addr[31:12] == PERIPH_BASE[31:12]) && !ram_hit;
    assign ram_idx    = bus.mem_cmd_addr[AW+1:2];
    assign accept     = bus.mem_cmd_valid && cmd_ready;
    assign pwait_done = (state == PWAIT) && (periph_ack || timeout_hit);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, RSP: begin
                state_next = IDLE;
                if (accept) begin
                    if (periph_hit) begin
                        state_next = PWAIT;
                    end else if (!bus.mem_cmd_wr) begin
                        state_next = RSP;
                    end
                end
            end
            PWAIT: begin
                if (pwait_done) begin
                    state_next = periph_wr ? IDLE : RSP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decode straight from state so they fall with an asynchronous reset.
    always_comb begin
        cmd_ready  = (state != PWAIT);
        rsp_ready  = (state == RSP);
        periph_req = (state == PWAIT);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            periph_wr    <= 1'b0;
            periph_addr  <= '0;
            periph_wdata <= '0;
            periph_be    <= '0;
            rsp_rdata    <= '0;
        end else begin
            if (accept && periph_hit) begin
                periph_wr    <= bus.mem_cmd_wr;
                periph_addr  <= bus.mem_cmd_addr[11:0];
                periph_wdata <= bus.mem_cmd_wdata;
                periph_be    <= bus.mem_cmd_be;
            end
            if (accept && !bus.mem_cmd_wr && !periph_hit) begin
                rsp_rdata <= ram_hit ? ram[ram_idx] : UNMAPPED_DATA;
            end else if (pwait_done && !periph_wr) begin
                rsp_rdata <= periph_ack ? periph_rdata : UNMAPPED_DATA;
            end
        end
    end

    // RAM keeps its contents across reset; writes are only blocked while reset is held.
    always_ff @(posedge clk) begin
        if (reset_ && accept && bus.mem_cmd_wr && ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_cmd_be[b]) begin
                    ram[ram_idx][8*b +: 8] <= bus.mem_cmd_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TW-1:0] timeout_cnt;

    // Fires in the TIMEOUT_CYCLES-th PWAIT cycle; a same-cycle ack still wins.
    assign timeout_hit = (state == PWAIT) && (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            timeout_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept && periph_hit) begin
                timeout_cnt <= '0;
            end else if (state == PWAIT) begin
                timeout_cnt <= timeout_cnt + TW'(1);
            end
            if (timeout_hit && !periph_ack) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign unused_bits = bus.mem_cmd_instr;
`else
    assign timeout_hit = 1'b0;
    assign unused_bits = bus.mem_cmd_instr ^ (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed vector table, multi-cycle sequences and random traffic vs. a behavioural model.
module tb_mem_bus_responder;

    localparam int          RAM_WORDS      = 2048;
    localparam logic [31:0] UNMAPPED       = 32'hDEAD_BEEF;
    localparam int          TIMEOUT_CYCLES = 255;

    logic        clk;
    logic        reset_;
    logic        periph_req;
    logic        periph_wr;
    logic [11:0] periph_addr;
    logic [31:0] periph_wdata;
    logic [3:0]  periph_be;
    logic        periph_ack;
    logic [31:0] periph_rdata;
`ifdef MEM_BUS_TIMEOUT_EN
    logic        timeout_err;
`endif

    mem_bus_responder_if bus ();

    mem_bus_responder dut (
        .clk          (clk),
        .reset_       (reset_),
        .bus          (bus),
        .periph_req   (periph_req),
        .periph_wr    (periph_wr),
        .periph_addr  (periph_addr),
        .periph_wdata (periph_wdata),
        .periph_be    (periph_be),
        .periph_ack   (periph_ack),
        .periph_rdata (periph_rdata)
`ifdef MEM_BUS_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_ram [RAM_WORDS];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ack_delay;
        logic [31:0] prdata;
        logic        exp_rsp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 0 = RAM, 1 = peripheral window, 2 = unmapped
    function automatic int region(input logic [31:0] a);
        if (a < 32'(RAM_WORDS * 4)) return 0;
        if (a[31:12] == 20'h80000) return 1;
        return 2;
    endfunction

    task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] be, input int ack_delay, input logic [31:0] prdata,
                                  output logic got_rsp, output logic [31:0] got_rdata);
        int          kind;
        logic [31:0] exp;
        kind      = region(addr);
        exp       = UNMAPPED;
        got_rsp   = 1'b0;
        got_rdata = '0;
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_wr    = wr;
        bus.mem_cmd_addr  = addr;
        bus.mem_cmd_wdata = wdata;
        bus.mem_cmd_be    = be;
        bus.mem_cmd_instr = 1'($urandom);
        @(negedge clk);
        check_output("cmd_ready_accept", bus.mem_cmd_ready, 1);
        @(posedge clk);
        #1;
        bus.mem_cmd_valid = 1'b0;
        bus.mem_cmd_addr  = $urandom;
        bus.mem_cmd_wdata = $urandom;
        if (kind == 0) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_ram[addr >> 2][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                exp = model_ram[addr >> 2];
            end
        end else if (kind == 1) begin
            for (int k = 0; k < ack_delay; k++) begin
                @(negedge clk);
                check_output("periph_req_held", periph_req, 1);
                check_output("periph_addr", periph_addr, addr[11:0]);
                check_output("periph_wr", periph_wr, wr);
                check_output("periph_wdata", periph_wdata, wdata);
                check_output("periph_be", periph_be, be);
                check_output("cmd_ready_pwait", bus.mem_cmd_ready, 0);
                if (k == ack_delay - 1) begin
                    periph_ack   = 1'b1;
                    periph_rdata = prdata;
                end
                @(posedge clk);
                #1;
                periph_ack   = 1'b0;
                periph_rdata = $urandom;
            end
            exp = prdata;
        end
        @(negedge clk);
        check_output("periph_req_low", periph_req, 0);
        check_output("rsp_ready", bus.mem_rsp_ready, !wr);
        got_rsp = bus.mem_rsp_ready;
        if (!wr) begin
            check_output("rsp_rdata", bus.mem_rsp_rdata, exp);
            got_rdata = bus.mem_rsp_rdata;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("rsp_one_cycle", bus.mem_rsp_ready, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        rsp;
        logic [31:0] rd;
        logic        wr;
        logic [31:0] addr;
        int          pick;

        reset_            = 1'b1;
        bus.mem_cmd_valid = 1'b0;
        bus.mem_cmd_instr = 1'b0;
        bus.mem_cmd_wr    = 1'b0;
        bus.mem_cmd_addr  = '0;
        bus.mem_cmd_wdata = '0;
        bus.mem_cmd_be    = '0;
        periph_ack        = 1'b0;
        periph_rdata      = '0;
        #1 reset_ = 1'b0;
        #2;
        check_output("reset_cmd_ready", bus.mem_cmd_ready, 1);
        check_output("reset_rsp_ready", bus.mem_rsp_ready, 0);
        check_output("reset_rsp_rdata", bus.mem_rsp_rdata, 0);
        check_output("reset_periph_req", periph_req, 0);
        check_output("reset_periph_wr", periph_wr, 0);
        check_output("reset_periph_addr", periph_addr, 0);
        check_output("reset_periph_wdata", periph_wdata, 0);
        check_output("reset_periph_be", periph_be, 0);
`ifdef MEM_BUS_TIMEOUT_EN
        check_output("reset_timeout_err", timeout_err, 0);
`endif
        #9 reset_ = 1'b1;
        @(posedge clk);
        #1;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b1111, 1, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 1, 32'h0, 1'b1, 32'h1122_3344};
        vecs[2]  = '{1'b1, 32'h0000_0013, 32'hAA00_0000, 4'b1000, 1, 32'h0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 1, 32'h0, 1'b1, 32'hAA22_3344};
        vecs[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'b1111, 3, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
        vecs[5]  = '{1'b0, 32'h4000_0000, 32'h0,         4'b1111, 1, 32'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 32'h4000_0010, 32'h5555_5555, 4'b1111, 1, 32'h0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0012, 32'h0,         4'b1111, 1, 32'h0, 1'b1, 32'hAA22_3344};
        vecs[8]  = '{1'b1, 32'h8000_0FFC, 32'h1234_5678, 4'b0101, 2, 32'h0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_1FFC, 32'h0BAD_F00D, 4'b1111, 1, 32'h0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_1FFC, 32'h0,         4'b1111, 1, 32'h0, 1'b1, 32'h0BAD_F00D};
        vecs[11] = '{1'b0, 32'h0000_2000, 32'h0,         4'b1111, 1, 32'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[12] = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 1, 32'h0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 1, 32'h0, 1'b1, 32'hAA22_3344};

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                           vecs[i].ack_delay, vecs[i].prdata, rsp, rd);
            check_output($sformatf("vec%0d_rsp", i), rsp, vecs[i].exp_rsp);
            if (vecs[i].exp_rsp) check_output($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // Preload the words used by the back-to-back and random phases.
        for (int w = 0; w < 72; w++) begin
            addr = (w < 64) ? 32'(w * 4) : 32'((RAM_WORDS - 72 + w) * 4);
            apply_stimulus(1'b1, addr, $urandom, 4'b1111, 1, 32'h0, rsp, rd);
        end

        // Back-to-back reads: second command accepted in the RSP cycle of the first.
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_wr    = 1'b0;
        bus.mem_cmd_addr  = 32'h0;
        @(negedge clk);
        check_output("b2b_ready0", bus.mem_cmd_ready, 1);
        @(posedge clk);
        #1;
        bus.mem_cmd_addr = 32'h4;
        @(negedge clk);
        check_output("b2b_rsp0_ready", bus.mem_rsp_ready, 1);
        check_output("b2b_rsp0_data", bus.mem_rsp_rdata, model_ram[0]);
        check_output("b2b_ready1", bus.mem_cmd_ready, 1);
        @(posedge clk);
        #1;
        bus.mem_cmd_valid = 1'b0;
        @(negedge clk);
        check_output("b2b_rsp1_ready", bus.mem_rsp_ready, 1);
        check_output("b2b_rsp1_data", bus.mem_rsp_rdata, model_ram[1]);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("b2b_idle", bus.mem_rsp_ready, 0);
        @(posedge clk);
        #1;

        for (int t = 0; t < 300; t++) begin
            pick = $urandom_range(0, 9);
            wr   = 1'($urandom);
            if (pick < 5) begin
                addr = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(RAM_WORDS - 8, RAM_WORDS - 1));
                addr = addr * 4 + 32'($urandom_range(0, 3));
            end else if (pick < 7) begin
                addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            end else begin
                addr = ($urandom_range(0, 1) == 1) ? 32'h0000_2000 + $urandom_range(0, 32'h3FFF_0000)
                                                   : 32'h8000_1000 + $urandom_range(0, 32'h0FFF_0000);
            end
            apply_stimulus(wr, addr, $urandom, 4'($urandom), $urandom_range(1, 5), $urandom, rsp, rd);
        end

        // Reset while waiting on the peripheral.
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_wr    = 1'b0;
        bus.mem_cmd_addr  = 32'h8000_0040;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.mem_cmd_valid = 1'b0;
        @(negedge clk);
        check_output("pre_reset_req", periph_req, 1);
        @(negedge clk);
        #2 reset_ = 1'b0;
        #1;
        check_output("rst_pwait_req", periph_req, 0);
        check_output("rst_pwait_rsp", bus.mem_rsp_ready, 0);
        check_output("rst_pwait_ready", bus.mem_cmd_ready, 1);
        check_output("rst_pwait_addr", periph_addr, 0);
        @(posedge clk);
        #1 reset_ = 1'b1;
        periph_ack   = 1'b1;
        periph_rdata = 32'h1357_9BDF;
        @(negedge clk);
        check_output("ack_ignored_req", periph_req, 0);
        @(posedge clk);
        #1 periph_ack = 1'b0;
        @(negedge clk);
        check_output("ack_ignored_rsp", bus.mem_rsp_ready, 0);
        @(posedge clk);
        #1;

        // Reset during the response cycle.
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_addr  = 32'h4000_0000;
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.mem_cmd_valid = 1'b0;
        @(negedge clk);
        check_output("rsp_before_reset", bus.mem_rsp_ready, 1);
        #1 reset_ = 1'b0;
        #1;
        check_output("rst_rsp_ready", bus.mem_rsp_ready, 0);
        check_output("rst_rsp_rdata", bus.mem_rsp_rdata, 0);
        @(posedge clk);
        #1 reset_ = 1'b1;
        @(negedge clk);
        check_output("post_reset_no_rsp", bus.mem_rsp_ready, 0);
        @(posedge clk);
        #1;

        apply_stimulus(1'b0, 32'h0000_0010, 32'h0, 4'b1111, 1, 32'h0, rsp, rd);
        check_output("ram_kept_over_reset", rd, model_ram[4]);

`ifdef MEM_BUS_TIMEOUT_EN
        begin
            int  req_cycles;
            logic seen;
            req_cycles = 0;
            seen       = 1'b0;
            bus.mem_cmd_valid = 1'b1;
            bus.mem_cmd_wr    = 1'b0;
            bus.mem_cmd_addr  = 32'h8000_0100;
            @(negedge clk);
            @(posedge clk);
            #1;
            bus.mem_cmd_valid = 1'b0;
            for (int c = 0; c < TIMEOUT_CYCLES + 20 && !seen; c++) begin
                @(negedge clk);
                if (bus.mem_rsp_ready) seen = 1'b1;
                else if (periph_req) req_cycles++;
            end
            check_output("timeout_rsp_seen", seen, 1);
            check_output("timeout_req_cycles", req_cycles, TIMEOUT_CYCLES);
            check_output("timeout_rdata", bus.mem_rsp_rdata, UNMAPPED);
            check_output("timeout_req_low", periph_req, 0);
            check_output("timeout_err_set", timeout_err, 1);
            @(posedge clk);
            #1;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
